// File: rtl/risc_pkg.sv
// Shared definitions for the 8-bit RISC core control path.
// Contents: default widths, opcode constants (ALU codes match the ALU's
// select values NOP..NOT), sequencer state encoding, instruction field
// positions and small opcode-classification helpers.
package risc_pkg;

  localparam int WRD_SIZE  = 8;
  localparam int SEL_WIDTH = 3;
  localparam int INSTR_W   = 16;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SRT  = 4'd6;
  localparam logic [3:0] OP_NOT  = 4'd7;
  localparam logic [3:0] OP_LDI  = 4'd8;
  localparam logic [3:0] OP_BEQ  = 4'd9;
  localparam logic [3:0] OP_JMP  = 4'd10;
  localparam logic [3:0] OP_HALT = 4'd11;

  localparam logic [2:0] SEL_NOP = 3'd0;
  localparam logic [2:0] SEL_SUB = 3'd2;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WB,
    ST_HALT
  } state_e;

  // Instruction field positions
  localparam int F_OP_HI   = 15;
  localparam int F_OP_LO   = 12;
  localparam int F_RD_HI   = 11;
  localparam int F_RD_LO   = 9;
  localparam int F_RS1_HI  = 8;
  localparam int F_RS1_LO  = 6;
  localparam int F_RS2_HI  = 5;
  localparam int F_RS2_LO  = 3;
  localparam int F_IMM8_HI = 7;
  localparam int F_IMM6_HI = 5;

  function automatic logic is_alu_op(input logic [3:0] op);
    return op[3] == 1'b0;
  endfunction

  function automatic logic is_illegal_op(input logic [3:0] op);
    return op[3:2] == 2'b11;
  endfunction

  // ADD..NOT and LDI write the register file; NOP does not
  function automatic logic writes_rf(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_LDI);
  endfunction

endpackage

// File: rtl/risc_ctrl_seq_if.sv
// Bus between the control sequencer and the rest of the core: instruction
// memory handshake, ALU select / zero flag, register-file control and
// status. master = sequencer side, slave = memory/ALU/regfile side.
interface risc_ctrl_seq_if #(
  parameter int wrd_size  = 8,
  parameter int sel_width = 3,
  parameter int instr_w   = 16
);
  logic [instr_w-1:0]   Imem_data;
  logic                 Imem_ack;
  logic                 Alu_zero_flg;
  logic                 Imem_req;
  logic [wrd_size-1:0]  Pc_out;
  logic [sel_width-1:0] Alu_sel;
  logic [2:0]           Rf_rd_addr1;
  logic [2:0]           Rf_rd_addr2;
  logic [2:0]           Rf_wr_addr;
  logic                 Rf_wr_en;
  logic                 Rf_wr_sel;
  logic [wrd_size-1:0]  Imm_out;
  logic                 Halted;
  logic                 Illegal_op;

  modport master (
    input  Imem_data, Imem_ack, Alu_zero_flg,
    output Imem_req, Pc_out, Alu_sel, Rf_rd_addr1, Rf_rd_addr2, Rf_wr_addr,
           Rf_wr_en, Rf_wr_sel, Imm_out, Halted, Illegal_op
  );

  modport slave (
    output Imem_data, Imem_ack, Alu_zero_flg,
    input  Imem_req, Pc_out, Alu_sel, Rf_rd_addr1, Rf_rd_addr2, Rf_wr_addr,
           Rf_wr_en, Rf_wr_sel, Imm_out, Halted, Illegal_op
  );
endinterface

// File: rtl/risc_pc_unit.sv
// Program counter: holds the instruction address and updates it by +1,
// by a sign-extended 6-bit branch offset, or by loading a jump target.
// All arithmetic wraps modulo 2^wrd_size.
// Ports: clk, rst (sync, active-high), inc/br/ld (one-hot update select,
// ld > br > inc), off6 (branch offset), tgt (jump target), pc (current PC).
module risc_pc_unit #(
  parameter int wrd_size = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inc,
  input  logic                br,
  input  logic                ld,
  input  logic [5:0]          off6,
  input  logic [wrd_size-1:0] tgt,
  output logic [wrd_size-1:0] pc
);

  localparam logic [wrd_size-1:0] ONE = 1;

  logic [wrd_size-1:0] off_ext;

  assign off_ext = {{(wrd_size-6){off6[5]}}, off6};

  always_ff @(posedge clk) begin
    if (rst)      pc <= '0;
    else if (ld)  pc <= tgt;
    else if (br)  pc <= pc + off_ext;
    else if (inc) pc <= pc + ONE;
  end

endmodule

// File: rtl/risc_ctrl_seq.sv
// Multi-cycle control sequencer for the 8-bit RISC core.
// FETCH -> DECODE -> EXEC -> WB -> FETCH; BEQ/JMP return to FETCH from EXEC,
// HALT is terminal until rst. Fetches over a req/ack handshake, drives the
// ALU select and register-file controls, and owns the PC (risc_pc_unit).
// Ports: clk, rst (sync, active-high), bus (risc_ctrl_seq_if.master).
module risc_ctrl_seq
  import risc_pkg::*;
#(
  parameter int wrd_size  = WRD_SIZE,
  parameter int sel_width = SEL_WIDTH,
  parameter int instr_w   = INSTR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  risc_ctrl_seq_if.master      bus
);

  state_e             state, state_nxt;
  logic [instr_w-1:0] ir;
  logic               illegal_q;
  logic [3:0]         op;
  logic               req, wr_en, wr_sel;
  logic [2:0]         alu_sel;
  logic               pc_inc, pc_br, pc_ld;
  logic [wrd_size-1:0] pc;

  assign op = ir[F_OP_HI:F_OP_LO];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_FETCH;
      ir        <= '0;
      illegal_q <= 1'b0;
    end else begin
      state <= state_nxt;
      // ack is only meaningful while fetching
      if (state == ST_FETCH && bus.Imem_ack) ir <= bus.Imem_data;
      if (state == ST_WB && is_illegal_op(op)) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    alu_sel   = SEL_NOP;
    wr_en     = 1'b0;
    wr_sel    = 1'b0;
    pc_inc    = 1'b0;
    pc_br     = 1'b0;
    pc_ld     = 1'b0;
    case (state)
      ST_FETCH: begin
        req = 1'b1;
        if (bus.Imem_ack) state_nxt = ST_DECODE;
      end
      ST_DECODE: state_nxt = (op == OP_HALT) ? ST_HALT : ST_EXEC;
      ST_EXEC: begin
        if (is_alu_op(op))     alu_sel = op[2:0];
        else if (op == OP_BEQ) alu_sel = SEL_SUB;
        if (op == OP_BEQ) begin
          pc_br     = bus.Alu_zero_flg;
          pc_inc    = !bus.Alu_zero_flg;
          state_nxt = ST_FETCH;
        end else if (op == OP_JMP) begin
          pc_ld     = 1'b1;
          state_nxt = ST_FETCH;
        end else begin
          state_nxt = ST_WB;
        end
      end
      ST_WB: begin
        wr_en     = writes_rf(op);
        wr_sel    = (op == OP_LDI);
        pc_inc    = 1'b1;
        state_nxt = ST_FETCH;
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_FETCH;
    endcase
  end

  risc_pc_unit #(.wrd_size(wrd_size)) u_pc (
    .clk  (clk),
    .rst  (rst),
    .inc  (pc_inc),
    .br   (pc_br),
    .ld   (pc_ld),
    .off6 (ir[F_IMM6_HI:0]),
    .tgt  (wrd_size'(ir[F_IMM8_HI:0])),
    .pc   (pc)
  );

  // Strobes are forced idle while rst is held so that the cycle in which
  // reset is first applied already shows reset values.
  assign bus.Imem_req    = req && !rst;
  assign bus.Alu_sel     = rst ? sel_width'(SEL_NOP) : sel_width'(alu_sel);
  assign bus.Rf_wr_en    = wr_en && !rst;
  assign bus.Rf_wr_sel   = wr_sel && !rst;
  assign bus.Pc_out      = pc;
  // BEQ compares the registers named in the rd/rs1 fields
  assign bus.Rf_rd_addr1 = (op == OP_BEQ) ? ir[F_RD_HI:F_RD_LO]   : ir[F_RS1_HI:F_RS1_LO];
  assign bus.Rf_rd_addr2 = (op == OP_BEQ) ? ir[F_RS1_HI:F_RS1_LO] : ir[F_RS2_HI:F_RS2_LO];
  assign bus.Rf_wr_addr  = ir[F_RD_HI:F_RD_LO];
  assign bus.Imm_out     = wrd_size'(ir[F_IMM8_HI:0]);
  assign bus.Halted      = (state == ST_HALT);
  assign bus.Illegal_op  = illegal_q;

endmodule

// File: tb/tb_risc_ctrl_seq.sv
// Testbench for risc_ctrl_seq: directed scenarios plus randomized
// instruction streams, checked against an instruction-level reference
// model (PC, sticky illegal flag, per-opcode latency and write rules).
module tb_risc_ctrl_seq;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] mpc;
  logic       milleg;

  always #5 clk = ~clk;

  risc_ctrl_seq_if bus ();

  risc_ctrl_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (pc_model=%0h t=%0t)", tag, got, exp, mpc, $time);
    end
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b1;
    bus.Imem_ack  = 1'b1;
    bus.Imem_data = 16'h1250;
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      chk_val("rst_req",     bus.Imem_req,   0);
      chk_val("rst_pc",      bus.Pc_out,     0);
      chk_val("rst_wr_en",   bus.Rf_wr_en,   0);
      chk_val("rst_wr_sel",  bus.Rf_wr_sel,  0);
      chk_val("rst_alu_sel", bus.Alu_sel,    0);
      chk_val("rst_halted",  bus.Halted,     0);
      chk_val("rst_illegal", bus.Illegal_op, 0);
      chk_val("rst_imm",     bus.Imm_out,    0);
      bus.Imem_ack  = 1'($urandom);
      bus.Imem_data = 16'($urandom);
      @(negedge clk);
    end
    rst = 1'b0;
    bus.Imem_ack = 1'b0;
    mpc    = 8'h00;
    milleg = 1'b0;
    #1;
  endtask

  // Fetch one instruction with dly wait cycles, then step through its
  // remaining cycles checking outputs against the instruction-level rules.
  task automatic run_instr(input logic [15:0] ir, input int dly, input logic zf);
    logic [3:0]        op;
    int                last;
    logic              wr;
    logic [2:0]        esel;
    logic signed [5:0] off;
    op = ir[15:12];
    for (int i = 0; i <= dly; i++) begin
      chk_val("fetch_req",     bus.Imem_req,   1);
      chk_val("fetch_pc",      bus.Pc_out,     mpc);
      chk_val("fetch_wr_en",   bus.Rf_wr_en,   0);
      chk_val("fetch_alu_sel", bus.Alu_sel,    0);
      chk_val("fetch_illegal", bus.Illegal_op, milleg);
      bus.Imem_ack     = (i == dly);
      bus.Imem_data    = (i == dly) ? ir : 16'($urandom);
      bus.Alu_zero_flg = 1'($urandom);
      @(negedge clk);
    end
    if (op == 4'd11) begin
      chk_val("halt_dec_req",    bus.Imem_req, 0);
      chk_val("halt_dec_halted", bus.Halted,   0);
      bus.Imem_ack = 1'($urandom);
      @(negedge clk);
      for (int i = 0; i < 20; i++) begin
        chk_val("halt_req",    bus.Imem_req, 0);
        chk_val("halt_halted", bus.Halted,   1);
        chk_val("halt_pc",     bus.Pc_out,   mpc);
        chk_val("halt_wr_en",  bus.Rf_wr_en, 0);
        bus.Imem_ack  = 1'($urandom);
        bus.Imem_data = 16'($urandom);
        @(negedge clk);
      end
      return;
    end
    last = (op == 4'd9 || op == 4'd10) ? 1 : 2;
    wr   = (op >= 4'd1 && op <= 4'd8);
    esel = (op <= 4'd7) ? op[2:0] : (op == 4'd9) ? 3'd2 : 3'd0;
    for (int k = 0; k <= last; k++) begin
      chk_val("stg_req",     bus.Imem_req,   0);
      chk_val("stg_pc",      bus.Pc_out,     mpc);
      chk_val("stg_halted",  bus.Halted,     0);
      chk_val("stg_illegal", bus.Illegal_op, milleg);
      chk_val("stg_alu_sel", bus.Alu_sel,    (k == 1) ? esel : 3'd0);
      chk_val("stg_wr_en",   bus.Rf_wr_en,   (k == 2) && wr);
      if (k == 2 && wr) begin
        chk_val("wb_wr_sel",  bus.Rf_wr_sel,  op == 4'd8);
        chk_val("wb_wr_addr", bus.Rf_wr_addr, ir[11:9]);
        if (op == 4'd8) chk_val("wb_imm", bus.Imm_out, ir[7:0]);
      end
      if (k == 1 && op <= 4'd7) begin
        chk_val("ex_rd1", bus.Rf_rd_addr1, ir[8:6]);
        chk_val("ex_rd2", bus.Rf_rd_addr2, ir[5:3]);
      end
      if (k == 1 && op == 4'd9) begin
        chk_val("beq_rd1", bus.Rf_rd_addr1, ir[11:9]);
        chk_val("beq_rd2", bus.Rf_rd_addr2, ir[8:6]);
      end
      // zero flag only carries the real answer during EXEC
      bus.Alu_zero_flg = (k == 1) ? zf : ~zf;
      bus.Imem_ack     = 1'($urandom);
      bus.Imem_data    = 16'($urandom);
      @(negedge clk);
    end
    bus.Imem_ack = 1'b0;
    off = ir[5:0];
    if (op == 4'd9)       mpc = zf ? 8'(int'(mpc) + int'(off)) : mpc + 8'd1;
    else if (op == 4'd10) mpc = ir[7:0];
    else                  mpc = mpc + 8'd1;
    if (op >= 4'd12) milleg = 1'b1;
  endtask

  initial begin
    logic [3:0] rop;
    int         r;
    rst = 1'b1;
    bus.Imem_ack     = 1'b0;
    bus.Imem_data    = '0;
    bus.Alu_zero_flg = 1'b0;
    mpc    = 8'h00;
    milleg = 1'b0;
    apply_reset(3);

    run_instr(16'h1250, 0, 1'b0);
    run_instr(16'h86A5, 0, 1'b0);
    run_instr(16'hA010, 0, 1'b0);
    run_instr(16'h903E, 0, 1'b1);
    run_instr(16'hA010, 1, 1'b0);
    run_instr(16'h903E, 0, 1'b0);
    run_instr(16'hA0FF, 0, 1'b0);
    run_instr(16'h0000, 3, 1'b0);
    run_instr(16'hA000, 2, 1'b0);
    run_instr(16'h903F, 0, 1'b1);
    run_instr(16'h0000, 0, 1'b0);
    run_instr(16'hC000, 0, 1'b0);
    run_instr(16'h0000, 1, 1'b0);
    run_instr(16'hB000, 0, 1'b0);
    apply_reset(2);

    // reset in the middle of a waiting fetch, with an ack during reset
    run_instr(16'h86A5, 0, 1'b0);
    chk_val("mid_req0", bus.Imem_req, 1);
    bus.Imem_ack = 1'b0;
    @(negedge clk);
    chk_val("mid_req1", bus.Imem_req, 1);
    apply_reset(2);
    run_instr(16'h1250, 0, 1'b0);

    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 99);
      if (r < 5)      rop = 4'(12 + $urandom_range(0, 3));
      else if (r < 8) rop = 4'd11;
      else            rop = 4'($urandom_range(0, 10));
      run_instr({rop, 12'($urandom)}, $urandom_range(0, 3), 1'($urandom));
      if (rop == 4'd11) apply_reset($urandom_range(1, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
